// File: rtl/row_stepper_pkg.sv
`default_nettype none
// ============================================================================
// Module   : row_stepper_pkg
// Purpose  : Shared state encoding and width/constant helpers for row_stepper.
// Revision : 1.0 - initial release
// ============================================================================
package row_stepper_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DIV   = 3'd1,
        ST_MUL   = 3'd2,
        ST_ARMED = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    localparam int c_TEXV_BITS      = 6;
    localparam int c_SIZE_W         = 11;
    localparam int c_MUL_STEPS      = 11;
    // Texture height of 32 pixels per unit of half-height, in fixed point
    localparam int c_DIVIDEND_BASE  = 32;

    function automatic int acc_width(input int frac);
        return frac + c_TEXV_BITS;
    endfunction

    function automatic int half_of(input int h_view);
        return h_view / 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/row_stepper_seq_divider.sv
`default_nettype none
// ============================================================================
// Module   : seq_divider
// Purpose  : Unsigned restoring divider, one quotient bit per cycle.
// Revision : 1.0 - initial release
// ============================================================================
module seq_divider #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         i_start,
    input  logic [W-1:0] i_dividend,
    input  logic [W-1:0] i_divisor,
    output logic         o_done,
    output logic [W-1:0] o_quotient
);

    localparam int CW = $clog2(W);
    localparam logic [CW-1:0] c_LAST = CW'(W - 1);

    logic          r_busy;
    logic [CW-1:0] r_cnt;
    logic [W-1:0]  r_rem;
    logic [W-1:0]  r_dvd;
    logic [W-1:0]  r_dvs;
    logic [W-1:0]  r_quo;

    logic [W:0]    w_shift;
    logic [W:0]    w_diff;
    logic          w_ge;
    logic [W-1:0]  w_rem_next;
    logic [W-1:0]  w_quo_next;

    assign w_shift    = {r_rem, r_dvd[W-1]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_diff     = w_shift - {1'b0, r_dvs};
    // Remainder stays below the divisor, so the top bit is always zero here
    assign w_rem_next = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
    assign w_quo_next = {r_quo[W-2:0], w_ge};

    // Final quotient is presented combinationally during the last step
    assign o_done     = r_busy && (r_cnt == c_LAST);
    assign o_quotient = w_quo_next;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_dvd  <= '0;
            r_dvs  <= '0;
            r_quo  <= '0;
        end else if (i_start) begin
            r_busy <= 1'b1;
            r_cnt  <= '0;
            r_rem  <= '0;
            r_dvd  <= i_dividend;
            r_dvs  <= i_divisor;
            r_quo  <= '0;
        end else if (r_busy) begin
            r_rem  <= w_rem_next;
            r_dvd  <= {r_dvd[W-2:0], 1'b0};
            r_quo  <= w_quo_next;
            r_cnt  <= r_cnt + CW'(1);
            if (r_cnt == c_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/row_stepper.sv
`default_nettype none
// ============================================================================
// Module   : row_stepper
// Purpose  : Per-line row descriptor latch with hblank step/offset setup and
//            per-pixel texv stepping for the row renderer.
// Revision : 1.0 - initial release
// ============================================================================
module row_stepper
    import row_stepper_pkg::*;
#(
    parameter int H_VIEW = 640,
    parameter int FRAC   = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  in_wall,
    input  logic        in_side,
    input  logic [10:0] in_size,
    input  logic [5:0]  in_texu,
    input  logic [9:0]  hpos,
    input  logic        line_start,
    output logic [1:0]  wall,
    output logic        side,
    output logic [10:0] size,
    output logic [5:0]  texu,
    output logic [5:0]  texv,
    output logic        row_valid
);

    localparam int AW   = acc_width(FRAC);
    localparam int HALF = half_of(H_VIEW);

    localparam logic [AW-1:0]         c_DIVIDEND = AW'(c_DIVIDEND_BASE << FRAC);
    localparam logic [c_SIZE_W-1:0]   c_HALF_SZ  = c_SIZE_W'(HALF);
    localparam logic [c_SIZE_W+1:0]   c_HALF_POS = (c_SIZE_W + 2)'(HALF);
    localparam logic [9:0]            c_LAST_H   = 10'(H_VIEW - 1);
    localparam logic [3:0]            c_MUL_LAST = 4'(c_MUL_STEPS - 1);

    state_t              r_state;
    logic                r_in_ready;
    logic [1:0]          r_wall;
    logic                r_side;
    logic [10:0]         r_size;
    logic [5:0]          r_texu;
    logic [AW-1:0]       r_step;
    logic [AW-1:0]       r_mcand;
    logic [10:0]         r_mplier;
    logic [AW-1:0]       r_prod;
    logic [AW-1:0]       r_acc;
    logic [AW-1:0]       r_acc_start;
    logic [3:0]          r_cnt;

    logic                w_div_start;
    logic                w_div_done;
    logic [AW-1:0]       w_quo;
    logic [10:0]         w_excess;
    logic [AW-1:0]       w_prod_next;
    logic [c_SIZE_W+1:0] w_sum;
    logic                w_adv;
    logic                w_restart;
    logic [AW-1:0]       w_acc_base;
    logic [AW-1:0]       w_acc_next;
    logic                w_row_valid;

    seq_divider #(
        .W (AW)
    ) u_div (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_start    (w_div_start),
        .i_dividend (c_DIVIDEND),
        .i_divisor  ({{(AW - c_SIZE_W){1'b0}}, in_size}),
        .o_done     (w_div_done),
        .o_quotient (w_quo)
    );

    // A zero-height wall never starts the divider; DIV falls straight through
    assign w_div_start = (r_state == ST_IDLE) && in_valid && (in_size != '0);
    assign w_excess    = (r_size > c_HALF_SZ) ? (r_size - c_HALF_SZ) : '0;
    assign w_prod_next = r_prod + (r_mplier[0] ? r_mcand : '0);

    assign w_sum       = {3'b000, hpos} + {2'b00, r_size};
    assign w_adv       = (w_sum >= c_HALF_POS);

    // A line_start while running restarts from the clipped offset in this cycle
    assign w_restart   = (r_state == ST_RUN) && line_start;
    assign w_acc_base  = w_restart ? r_acc_start : r_acc;
    assign w_acc_next  = w_acc_base + (w_adv ? r_step : '0);

    // hpos==0 must already be valid, so the ARMED->RUN cycle counts as visible
    assign w_row_valid = (r_state == ST_RUN) || ((r_state == ST_ARMED) && line_start);

    assign in_ready  = r_in_ready;
    assign wall      = r_wall;
    assign side      = r_side;
    assign size      = r_size;
    assign texu      = r_texu;
    assign row_valid = w_row_valid;
    assign texv      = w_row_valid ? w_acc_base[FRAC+5:FRAC] : '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_wall      <= '0;
            r_side      <= 1'b0;
            r_size      <= '0;
            r_texu      <= '0;
            r_step      <= '0;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_prod      <= '0;
            r_acc       <= '0;
            r_acc_start <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_wall     <= in_wall;
                        r_side     <= in_side;
                        r_size     <= in_size;
                        r_texu     <= in_texu;
                        r_in_ready <= 1'b0;
                        r_state    <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    if ((r_size == '0) || w_div_done) begin
                        r_step   <= (r_size == '0) ? '0 : w_quo;
                        r_mcand  <= (r_size == '0) ? '0 : w_quo;
                        r_mplier <= w_excess;
                        r_prod   <= '0;
                        r_cnt    <= '0;
                        r_state  <= ST_MUL;
                    end
                end
                ST_MUL: begin
                    r_prod   <= w_prod_next;
                    r_mcand  <= {r_mcand[AW-2:0], 1'b0};
                    r_mplier <= {1'b0, r_mplier[10:1]};
                    r_cnt    <= r_cnt + 4'd1;
                    if (r_cnt == c_MUL_LAST) begin
                        r_acc       <= w_prod_next;
                        r_acc_start <= w_prod_next;
                        r_state     <= ST_ARMED;
                    end
                end
                ST_ARMED: begin
                    if (line_start) begin
                        r_acc   <= w_acc_next;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_acc <= w_acc_next;
                    if (!line_start && (hpos == c_LAST_H)) begin
                        r_in_ready <= 1'b1;
                        r_state    <= ST_IDLE;
                    end
                end
                default: begin
                    r_in_ready <= 1'b1;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
